// File: rtl/config_reg_bank.sv
// Bank of multi-byte configuration registers loaded over the GPIO write bus.
// Bytes shift into per-register shadows; a commit command moves pending shadows to the outputs at once.
module config_reg_bank #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = 4,
  parameter int BASE_ADDR  = 0,
  parameter logic [WORD_WIDTH*NUM_WORDS-1:0] RESET_VALUE = '0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [31:0]                           i_gpio_in,
  output logic [NUM_REGS*WORD_WIDTH*NUM_WORDS-1:0] o_reg_out,
  output logic [NUM_REGS-1:0]                   o_reg_update,
  output logic [NUM_REGS-1:0]                   o_pending,
  output logic [NUM_REGS-1:0]                   o_err_partial
);

  localparam int REG_W = WORD_WIDTH * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] CMD_ADDR = ADDR_WIDTH'(BASE_ADDR + NUM_REGS);
  localparam logic [WORD_WIDTH-1:0] OP_COMMIT = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] OP_ABORT  = WORD_WIDTH'(2);

  logic                  r_s1, r_s2, r_s3;
  logic                  w_event;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WORD_WIDTH-1:0] w_data;
  logic                  w_commit;
  logic                  w_abort;
  logic                  w_unused;

  // Sync flops reset high so a strobe held through reset release is not seen as an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_gpio_in[24];
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_event  = r_s2 & ~r_s3;
  assign w_addr   = i_gpio_in[ADDR_WIDTH-1:0];
  assign w_data   = i_gpio_in[16 +: WORD_WIDTH];
  assign w_commit = w_event && (w_addr == CMD_ADDR) && (w_data == OP_COMMIT);
  assign w_abort  = w_event && (w_addr == CMD_ADDR) && (w_data == OP_ABORT);
  assign w_unused = &{1'b0, i_gpio_in[31:25]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] REG_ADDR = ADDR_WIDTH'(BASE_ADDR + gi);

      logic [REG_W-1:0] r_shadow;
      logic [REG_W-1:0] r_out;
      logic [CNT_W-1:0] r_cnt;
      logic             r_pending;
      logic             r_err;
      logic             r_update;
      logic [REG_W-1:0] w_shift;
      logic             w_write;

      if (NUM_WORDS > 1) begin : g_shift
        assign w_shift = {r_shadow[REG_W-WORD_WIDTH-1:0], w_data};
      end else begin : g_load
        assign w_shift = w_data;
      end

      assign w_write = w_event && (w_addr == REG_ADDR);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_shadow  <= RESET_VALUE;
          r_out     <= RESET_VALUE;
          r_cnt     <= '0;
          r_pending <= 1'b0;
          r_err     <= 1'b0;
          r_update  <= 1'b0;
        end else begin
          r_update <= 1'b0;
          if (w_write) begin
            r_shadow  <= w_shift;
            r_pending <= 1'b1;
            if (r_cnt != CNT_FULL) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (w_commit && r_pending) begin
            r_out     <= r_shadow;
            r_update  <= 1'b1;
            r_err     <= r_err | (r_cnt != CNT_FULL);
            r_pending <= 1'b0;
            r_cnt     <= '0;
          end else if (w_abort) begin
            r_shadow  <= r_out;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
          end
        end
      end

      assign o_reg_out[gi*REG_W +: REG_W] = r_out;
      assign o_reg_update[gi]             = r_update;
      assign o_pending[gi]                = r_pending;
      assign o_err_partial[gi]            = r_err;
    end
  endgenerate

endmodule

// File: tb/tb_config_reg_bank.sv
// Directed bench for config_reg_bank: byte loads, commit/abort, strobe sync and reset behaviour.
module tb_config_reg_bank;

  localparam logic [31:0] RV = 32'hCAFE_F00D;

  logic         clk;
  logic         rst_n;
  logic [31:0]  gpio;
  logic [127:0] reg_out;
  logic [3:0]   reg_update;
  logic [3:0]   pending;
  logic [3:0]   err_partial;

  int checks;
  int errors;

  config_reg_bank #(
    .WORD_WIDTH (8),
    .NUM_WORDS  (4),
    .ADDR_WIDTH (16),
    .NUM_REGS   (4),
    .BASE_ADDR  (0),
    .RESET_VALUE(RV)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_gpio_in    (gpio),
    .o_reg_out    (reg_out),
    .o_reg_update (reg_update),
    .o_pending    (pending),
    .o_err_partial(err_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Raise w_clk for hi cycles with addr/data held; addr/data stay put after w_clk drops.
  task automatic drive(input logic [15:0] addr, input logic [7:0] data, input int hi);
    gpio = {7'd0, 1'b1, data, addr};
    repeat (hi) @(negedge clk);
    gpio[24] = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data, input int hi);
    drive(addr, data, hi);
    repeat (4) @(negedge clk);
  endtask

  // Command with a one-cycle strobe; checks the update pulse lands on exactly one cycle.
  task automatic cmd(input string tag, input logic [7:0] op, input logic [3:0] exp_upd);
    drive(16'd4, op, 1);
    @(negedge clk);
    check({tag, "_upd_early"}, {124'd0, reg_update}, {124'd0, 4'b0000});
    @(negedge clk);
    check({tag, "_upd_pulse"}, {124'd0, reg_update}, {124'd0, exp_upd});
    @(negedge clk);
    check({tag, "_upd_after"}, {124'd0, reg_update}, {124'd0, 4'b0000});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    gpio   = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", reg_out, {RV, RV, RV, RV});
    check("rst_pend", {124'd0, pending}, 128'd0);
    check("rst_upd", {124'd0, reg_update}, 128'd0);
    check("rst_err", {124'd0, err_partial}, 128'd0);
    repeat (10) @(negedge clk);
    check("idle_pend", {124'd0, pending}, 128'd0);

    // Full four-byte load into reg 1
    wr(16'd1, 8'h12, 2);
    wr(16'd1, 8'h34, 2);
    wr(16'd1, 8'h56, 2);
    wr(16'd1, 8'h78, 2);
    check("r1_pend", {124'd0, pending}, {124'd0, 4'b0010});
    check("r1_precommit", reg_out, {RV, RV, RV, RV});
    cmd("c1", 8'h01, 4'b0010);
    check("c1_out", reg_out, {RV, RV, 32'h1234_5678, RV});
    check("c1_pend", {124'd0, pending}, 128'd0);
    check("c1_err", {124'd0, err_partial}, 128'd0);

    // Load reg 0 then abort
    wr(16'd0, 8'hAA, 2);
    wr(16'd0, 8'hBB, 2);
    wr(16'd0, 8'hCC, 2);
    wr(16'd0, 8'hDD, 2);
    check("r0_pend", {124'd0, pending}, {124'd0, 4'b0001});
    check("r0_out", reg_out, {RV, RV, 32'h1234_5678, RV});
    cmd("a1", 8'h02, 4'b0000);
    check("a1_pend", {124'd0, pending}, 128'd0);
    check("a1_out", reg_out, {RV, RV, 32'h1234_5678, RV});
    // One byte on top of the restored shadow exposes it; partial count flags error
    wr(16'd0, 8'h11, 2);
    cmd("c2", 8'h01, 4'b0001);
    check("c2_out", reg_out, {RV, RV, 32'h1234_5678, 32'hFEF0_0D11});
    check("c2_err", {124'd0, err_partial}, {124'd0, 4'b0001});
    cmd("a2", 8'h02, 4'b0000);
    check("a2_err", {124'd0, err_partial}, 128'd0);

    // Two-byte partial load into reg 3
    wr(16'd3, 8'h01, 2);
    wr(16'd3, 8'h02, 2);
    cmd("c3", 8'h01, 4'b1000);
    check("c3_out", reg_out, {32'hF00D_0102, RV, 32'h1234_5678, 32'hFEF0_0D11});
    check("c3_err", {124'd0, err_partial}, {124'd0, 4'b1000});

    // Short and long strobes each give exactly one byte
    wr(16'd2, 8'h5A, 1);
    wr(16'd2, 8'hA5, 100);
    wr(16'd2, 8'h3C, 1);
    wr(16'd2, 8'hC3, 1);
    cmd("c4", 8'h01, 4'b0100);
    check("c4_out", reg_out, {32'hF00D_0102, 32'h5AA5_3CC3, 32'h1234_5678, 32'hFEF0_0D11});
    check("c4_err", {124'd0, err_partial}, {124'd0, 4'b1000});

    // Five bytes: oldest discarded, counter saturates at full; stray writes ignored
    for (int b = 1; b <= 5; b++) wr(16'd1, 8'(b), 2);
    wr(16'd4, 8'h03, 2);
    wr(16'd9, 8'h77, 2);
    check("stray_pend", {124'd0, pending}, {124'd0, 4'b0010});
    check("stray_out", reg_out, {32'hF00D_0102, 32'h5AA5_3CC3, 32'h1234_5678, 32'hFEF0_0D11});
    cmd("c5", 8'h01, 4'b0010);
    check("c5_out", reg_out, {32'hF00D_0102, 32'h5AA5_3CC3, 32'h0203_0405, 32'hFEF0_0D11});
    check("c5_err", {124'd0, err_partial}, {124'd0, 4'b1000});

    // Commit with nothing pending
    cmd("c6", 8'h01, 4'b0000);
    check("c6_out", reg_out, {32'hF00D_0102, 32'h5AA5_3CC3, 32'h0203_0405, 32'hFEF0_0D11});

    // Async reset mid-sequence with w_clk held high across release
    wr(16'd0, 8'h99, 2);
    check("pre_rst_pend", {124'd0, pending}, {124'd0, 4'b0001});
    gpio = {7'd0, 1'b1, 8'h66, 16'd0};
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", reg_out, {RV, RV, RV, RV});
    check("arst_pend", {124'd0, pending}, 128'd0);
    check("arst_err", {124'd0, err_partial}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_pend", {124'd0, pending}, 128'd0);
    gpio[24] = 1'b0;
    repeat (5) @(negedge clk);
    check("drop_pend", {124'd0, pending}, 128'd0);
    wr(16'd0, 8'h44, 2);
    cmd("c7", 8'h01, 4'b0001);
    check("c7_out", reg_out, {RV, RV, RV, 32'hFEF0_0D44});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
